// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared opcodes, flush FSM state type and counter width for
//               the branch hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [4:0] OP_BEQ = 5'b01000;
    localparam logic [4:0] OP_BGT = 5'b01001;
    localparam logic [4:0] OP_BNE = 5'b01010;
    localparam logic [4:0] OP_BLT = 5'b01011;

    // Wide enough for the largest legal flush window (15).
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_hazard_ctrl_comparator.sv
// ============================================================================
// Module      : branch_hazard_ctrl_comparator
// Description : Full-width equality / greater-than comparator, signed or
//               unsigned selected at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_hazard_ctrl_comparator #(
    parameter int DATA_W     = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_eq,
    output logic              o_gt
);

    assign o_eq = (i_a == i_b);

    generate
        if (SIGNED_CMP) begin : g_signed
            assign o_gt = ($signed(i_a) > $signed(i_b));
        end else begin : g_unsigned
            assign o_gt = (i_a > i_b);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
// ============================================================================
// Module      : branch_hazard_ctrl
// Description : EX-stage branch resolution with a multi-cycle flush window.
//               Optional branch statistics enabled by macro BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_hazard_ctrl
    import branch_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int OP_W         = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter bit SIGNED_CMP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branchE,
    input  logic [OP_W-1:0]   opCode,
    input  logic [DATA_W-1:0] opeA,
    input  logic [DATA_W-1:0] opeB,
    input  logic              hold,
    output logic              select_pc,
    output logic              flush,
    output logic              stall,
    output logic              busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       taken_count
`endif
);

    localparam logic [OP_W-1:0]  c_op_beq   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0]  c_op_bgt   = OP_W'(OP_BGT);
    localparam logic [OP_W-1:0]  c_op_bne   = OP_W'(OP_BNE);
    localparam logic [OP_W-1:0]  c_op_blt   = OP_W'(OP_BLT);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(FLUSH_CYCLES - 1);

    flush_state_t     r_state;
    flush_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_eq;
    logic w_gt;
    logic w_lt;
    logic w_cond;
    logic w_evaluated;
    logic w_taken;

    branch_hazard_ctrl_comparator #(
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .i_a  (opeA),
        .i_b  (opeB),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    assign w_lt = ~w_eq & ~w_gt;

    always_comb begin
        w_cond = 1'b0;
        case (opCode)
            c_op_beq: w_cond = w_eq;
            c_op_bgt: w_cond = w_gt;
            c_op_bne: w_cond = ~w_eq;
            c_op_blt: w_cond = w_lt;
            default:  w_cond = 1'b0;
        endcase
    end

    // A branch seen while flushing is itself a squashed instruction.
    assign w_evaluated = branchE & (r_state == IDLE) & ~hold;
    assign w_taken     = w_evaluated & w_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        select_pc   = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                select_pc = w_taken;
                flush     = w_taken;
                stall     = w_taken;
                if (w_taken && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                // Hold freezes the window so it always spans FLUSH_CYCLES real cycles.
                if (!hold) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (rst) begin
            select_pc = 1'b0;
            flush     = 1'b0;
            stall     = 1'b0;
            busy      = 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_evaluated) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_taken) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
// ============================================================================
// Module      : tb_branch_hazard_ctrl
// Description : Directed self-checking bench; instance A uses FLUSH_CYCLES=2
//               unsigned, instance B uses FLUSH_CYCLES=3 signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_hazard_ctrl;

    logic        clk;
    logic        rst;

    logic        a_br, a_hold;
    logic [4:0]  a_op;
    logic [31:0] a_a, a_b;
    logic        a_sp, a_fl, a_st, a_bz;

    logic        b_br, b_hold;
    logic [4:0]  b_op;
    logic [31:0] b_a, b_b;
    logic        b_sp, b_fl, b_st, b_bz;

`ifdef BRANCH_STATS_EN
    logic [31:0] a_brc, a_tkc, b_brc, b_tkc;
`endif

    int tests_run;
    int tests_failed;

    branch_hazard_ctrl #(
        .DATA_W(32), .OP_W(5), .FLUSH_CYCLES(2), .SIGNED_CMP(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .branchE(a_br), .opCode(a_op),
        .opeA(a_a), .opeB(a_b), .hold(a_hold),
        .select_pc(a_sp), .flush(a_fl), .stall(a_st), .busy(a_bz)
`ifdef BRANCH_STATS_EN
        , .br_count(a_brc), .taken_count(a_tkc)
`endif
    );

    branch_hazard_ctrl #(
        .DATA_W(32), .OP_W(5), .FLUSH_CYCLES(3), .SIGNED_CMP(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .branchE(b_br), .opCode(b_op),
        .opeA(b_a), .opeB(b_b), .hold(b_hold),
        .select_pc(b_sp), .flush(b_fl), .stall(b_st), .busy(b_bz)
`ifdef BRANCH_STATS_EN
        , .br_count(b_brc), .taken_count(b_tkc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] BEQ = 5'b01000;
    localparam logic [4:0] BGT = 5'b01001;
    localparam logic [4:0] BNE = 5'b01010;
    localparam logic [4:0] BLT = 5'b01011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic br, input logic [4:0] op,
                           input logic [31:0] x, input logic [31:0] y, input logic h);
        a_br = br; a_op = op; a_a = x; a_b = y; a_hold = h;
    endtask

    task automatic drive_b(input logic br, input logic [4:0] op,
                           input logic [31:0] x, input logic [31:0] y, input logic h);
        b_br = br; b_op = op; b_a = x; b_b = y; b_hold = h;
    endtask

    // Expected vector is {select_pc, flush, stall, busy}; checks then advances one cycle.
    task automatic ck_a(input string tag, input logic [3:0] exp);
        @(negedge clk);
        chk(tag, {28'd0, a_sp, a_fl, a_st, a_bz}, {28'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic ck_b(input string tag, input logic [3:0] exp);
        @(negedge clk);
        chk(tag, {28'd0, b_sp, b_fl, b_st, b_bz}, {28'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;

        // Reset: even a taken-looking branch must produce nothing while rst is high.
        drive_a(1'b1, BEQ, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        chk("a_in_reset", {28'd0, a_sp, a_fl, a_st, a_bz}, 32'd0);
        chk("b_in_reset", {28'd0, b_sp, b_fl, b_st, b_bz}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_a("a_after_reset", 4'b0000);

        // BEQ taken, two-cycle flush window.
        drive_a(1'b1, BEQ, 32'd5, 32'd5, 1'b0);
        ck_a("beq_c0", 4'b1110);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_a("beq_c1", 4'b0101);
        ck_a("beq_c2", 4'b0000);

        // BNE not taken / taken.
        drive_a(1'b1, BNE, 32'd3, 32'd3, 1'b0);
        ck_a("bne_eq", 4'b0000);
        drive_a(1'b1, BNE, 32'd3, 32'd4, 1'b0);
        ck_a("bne_ne", 4'b1110);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_a("bne_flush", 4'b0101);
        ck_a("bne_idle", 4'b0000);

        // Unsupported opcode and branchE low.
        drive_a(1'b1, 5'b00000, 32'd9, 32'd9, 1'b0);
        ck_a("bad_opcode", 4'b0000);
        drive_a(1'b0, BEQ, 32'd9, 32'd9, 1'b0);
        ck_a("no_branch", 4'b0000);

        // BLT 0xFFFFFFFF vs 1: signed taken (B), unsigned not taken (A).
        drive_a(1'b1, BLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        ck_a("blt_unsigned", 4'b0000);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        drive_b(1'b1, BLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        ck_b("blt_signed_c0", 4'b1110);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_b("blt_signed_c1", 4'b0101);
        ck_b("blt_signed_c2", 4'b0101);
        ck_b("blt_signed_c3", 4'b0000);

        // BGT 0x80000000 vs 1: signed false.
        drive_b(1'b1, BGT, 32'h8000_0000, 32'd1, 1'b0);
        ck_b("bgt_signed", 4'b0000);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

        // Unsigned BGT taken, then a second taken branch arriving during FLUSH.
        drive_a(1'b1, BGT, 32'h8000_0000, 32'd1, 1'b0);
        ck_a("bgt_unsigned", 4'b1110);
        drive_a(1'b1, BEQ, 32'd6, 32'd6, 1'b0);
        ck_a("branch_in_flush", 4'b0101);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_a("flush_on_schedule", 4'b0000);

        // Hold in IDLE defers the branch; it issues once when hold drops.
        drive_a(1'b1, BEQ, 32'd1, 32'd1, 1'b1);
        ck_a("hold_idle", 4'b0000);
        drive_a(1'b1, BEQ, 32'd1, 32'd1, 1'b0);
        ck_a("hold_release", 4'b1110);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_a("hold_release_flush", 4'b0101);
        ck_a("hold_release_idle", 4'b0000);

        // FLUSH_CYCLES=3 with two hold cycles: flush high for five cycles.
        drive_b(1'b1, BEQ, 32'd7, 32'd7, 1'b0);
        ck_b("hflush_c0", 4'b1110);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_b("hflush_c1", 4'b0101);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        ck_b("hflush_c2", 4'b0101);
        ck_b("hflush_c3", 4'b0101);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ck_b("hflush_c4", 4'b0101);
        ck_b("hflush_c5", 4'b0000);

        // Reset while in FLUSH with cnt = 2.
        drive_b(1'b1, BEQ, 32'd7, 32'd7, 1'b0);
        ck_b("rst_flush_c0", 4'b1110);
        drive_b(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        ck_b("rst_flush_during", 4'b0000);
        rst = 1'b0;
        ck_b("rst_flush_after", 4'b0000);
`ifdef BRANCH_STATS_EN
        chk("b_brc_after_rst", b_brc, 32'd0);
        chk("b_tkc_after_rst", b_tkc, 32'd0);
        chk("a_brc_after_rst", a_brc, 32'd0);
        chk("a_tkc_after_rst", a_tkc, 32'd0);

        // One taken, one ignored-in-flush, one evaluated not-taken.
        drive_a(1'b1, BEQ, 32'd2, 32'd2, 1'b0);
        ck_a("stats_c0", 4'b1110);
        ck_a("stats_c1", 4'b0101);
        drive_a(1'b1, BNE, 32'd3, 32'd3, 1'b0);
        ck_a("stats_c2", 4'b0000);
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("a_br_count", a_brc, 32'd2);
        chk("a_taken_count", a_tkc, 32'd1);
        chk("b_br_count_idle", b_brc, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
